// File: rtl/core_pkg.sv
// Shared types and constants for the 16-bit pipelined core.
package core_pkg;

    localparam int              WORD_W    = 16;
    localparam logic [WORD_W-1:0] NOP_INSTR = 16'h0000;

    typedef enum logic [1:0] {
        S_BOOT,
        S_RUN,
        S_HALT
    } fetch_state_t;

    typedef struct packed {
        logic [WORD_W-1:0] pc;
        logic [WORD_W-1:0] pc1;
        logic [WORD_W-1:0] instr;
        logic              valid;
    } ifid_t;

endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline register: load captures a fetch, bubble zeroes instr/valid, otherwise holds.
// Latency 1 cycle; no backpressure of its own (hold is driven by the fetch stage).
module if_id_reg
    import core_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic              bubble,
    input  logic [WORD_W-1:0] pc,
    input  logic [WORD_W-1:0] pc1,
    input  logic [WORD_W-1:0] instr,
    output ifid_t             ifid
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ifid <= '0;
        end else if (load) begin
            // pc fields load even for a bubble so decode always sees a coherent address
            ifid.pc  <= pc;
            ifid.pc1 <= pc1;
            if (bubble) begin
                ifid.instr <= NOP_INSTR;
                ifid.valid <= 1'b0;
            end else begin
                ifid.instr <= instr;
                ifid.valid <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/if_stage.sv
// Instruction fetch: owns PC, addresses the ROM, fills IF/ID; latency 1 cycle ROM->IF/ID.
// Backpressure: stall_i holds PC and IF/ID; optional IF_PERF_CNT_EN adds fetch/bubble counters.
module if_stage
    import core_pkg::*;
#(
    parameter logic [15:0] RESET_PC   = 16'h0000,
    parameter int          IMEM_DEPTH = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              stall_i,
    input  logic              flush_i,
    input  logic              redirect_i,
    input  logic [WORD_W-1:0] redirect_pc_i,
    output logic [WORD_W-1:0] imem_pc_o,
    input  logic [WORD_W-1:0] imem_instr_i,
    output logic [WORD_W-1:0] ifid_pc_o,
    output logic [WORD_W-1:0] ifid_pc1_o,
    output logic [WORD_W-1:0] ifid_instr_o,
    output logic              ifid_valid_o,
    output logic              halted_o
`ifdef IF_PERF_CNT_EN
    ,
    output logic [15:0]       perf_fetch_o,
    output logic [15:0]       perf_bubble_o
`endif
);

    localparam logic [WORD_W:0] DEPTH_LIMIT = (WORD_W+1)'(IMEM_DEPTH);

    fetch_state_t      state, state_nxt;
    logic [WORD_W-1:0] pc, pc_nxt, pc_inc;
    logic              ifid_load, ifid_bubble;
    ifid_t             ifid;

    function automatic logic out_of_range(input logic [WORD_W-1:0] a);
        return {1'b0, a} >= DEPTH_LIMIT;
    endfunction

    assign pc_inc = pc + 16'd1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_BOOT;
            pc    <= RESET_PC;
        end else begin
            state <= state_nxt;
            pc    <= pc_nxt;
        end
    end

    // redirect beats stall beats the halt check beats a normal fetch
    always_comb begin
        state_nxt   = state;
        pc_nxt      = pc;
        ifid_load   = 1'b0;
        ifid_bubble = 1'b0;
        case (state)
            S_BOOT: begin
                state_nxt   = S_RUN;
                pc_nxt      = RESET_PC;
                ifid_load   = 1'b1;
                ifid_bubble = 1'b1;
            end
            S_RUN: begin
                if (redirect_i) begin
                    pc_nxt      = redirect_pc_i;
                    ifid_load   = 1'b1;
                    ifid_bubble = 1'b1;
                end else if (stall_i) begin
                    pc_nxt = pc;
                end else if (out_of_range(pc)) begin
                    state_nxt   = S_HALT;
                    ifid_load   = 1'b1;
                    ifid_bubble = 1'b1;
                end else begin
                    pc_nxt      = pc_inc;
                    ifid_load   = 1'b1;
                    ifid_bubble = flush_i;
                end
            end
            S_HALT: begin
                if (redirect_i && !out_of_range(redirect_pc_i)) begin
                    state_nxt   = S_RUN;
                    pc_nxt      = redirect_pc_i;
                    ifid_load   = 1'b1;
                    ifid_bubble = 1'b1;
                end
            end
            default: state_nxt = S_BOOT;
        endcase
    end

    if_id_reg u_if_id_reg (
        .clk    (clk),
        .rst    (rst),
        .load   (ifid_load),
        .bubble (ifid_bubble),
        .pc     (pc),
        .pc1    (pc_inc),
        .instr  (imem_instr_i),
        .ifid   (ifid)
    );

    assign imem_pc_o    = pc;
    assign ifid_pc_o    = ifid.pc;
    assign ifid_pc1_o   = ifid.pc1;
    assign ifid_instr_o = ifid.instr;
    assign ifid_valid_o = ifid.valid;
    assign halted_o     = (state == S_HALT);

`ifdef IF_PERF_CNT_EN
    logic fetch_inc, bubble_inc;

    assign fetch_inc  = ifid_load && !ifid_bubble;
    assign bubble_inc = ifid_load && ifid_bubble && (state != S_HALT);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            perf_fetch_o  <= '0;
            perf_bubble_o <= '0;
        end else begin
            if (fetch_inc && perf_fetch_o != 16'hFFFF)
                perf_fetch_o <= perf_fetch_o + 16'd1;
            if (bubble_inc && perf_bubble_o != 16'hFFFF)
                perf_bubble_o <= perf_bubble_o + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_if_stage.sv
// Bench for if_stage: rule-level reference model checked every cycle plus directed literal checks.
module tb_if_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        stall_i, flush_i, redirect_i;
    logic [15:0] redirect_pc_i;
    logic [15:0] imem_pc_o, imem_instr_i;
    logic [15:0] ifid_pc_o, ifid_pc1_o, ifid_instr_o;
    logic        ifid_valid_o, halted_o;
`ifdef IF_PERF_CNT_EN
    logic [15:0] perf_fetch_o, perf_bubble_o;
`endif

    int pass_cnt  = 0;
    int total_cnt = 0;

    logic [15:0] rom [16];

    always #5 clk = ~clk;

    // combinational ROM; out-of-range addresses read as zero
    assign imem_instr_i = (imem_pc_o < 16) ? rom[imem_pc_o[3:0]] : 16'h0000;

    if_stage #(.RESET_PC(16'h0000), .IMEM_DEPTH(16)) dut (
        .clk           (clk),
        .rst           (rst),
        .stall_i       (stall_i),
        .flush_i       (flush_i),
        .redirect_i    (redirect_i),
        .redirect_pc_i (redirect_pc_i),
        .imem_pc_o     (imem_pc_o),
        .imem_instr_i  (imem_instr_i),
        .ifid_pc_o     (ifid_pc_o),
        .ifid_pc1_o    (ifid_pc1_o),
        .ifid_instr_o  (ifid_instr_o),
        .ifid_valid_o  (ifid_valid_o),
        .halted_o      (halted_o)
`ifdef IF_PERF_CNT_EN
        ,
        .perf_fetch_o  (perf_fetch_o),
        .perf_bubble_o (perf_bubble_o)
`endif
    );

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        total_cnt++;
        if (act !== exp)
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        else
            pass_cnt++;
    endtask

    // Reference model: what the fetch stage must hold after each edge, from the stage's rules.
    logic [15:0] m_pc, m_ifid_pc, m_ifid_pc1, m_ifid_instr;
    logic        m_ifid_valid, m_boot, m_halt;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_pc = 16'h0000; m_boot = 1'b1; m_halt = 1'b0;
            m_ifid_pc = 0; m_ifid_pc1 = 0; m_ifid_instr = 0; m_ifid_valid = 1'b0;
        end else if (m_boot) begin
            m_boot = 1'b0; m_pc = 16'h0000;
            m_ifid_instr = 0; m_ifid_valid = 1'b0;
        end else if (m_halt) begin
            if (redirect_i && redirect_pc_i < 16) begin
                m_halt = 1'b0; m_pc = redirect_pc_i;
                m_ifid_instr = 0; m_ifid_valid = 1'b0;
            end
        end else if (redirect_i) begin
            m_pc = redirect_pc_i;
            m_ifid_instr = 0; m_ifid_valid = 1'b0;
        end else if (stall_i) begin
            // everything holds
        end else if (m_pc >= 16) begin
            m_halt = 1'b1;
            m_ifid_instr = 0; m_ifid_valid = 1'b0;
        end else begin
            m_ifid_pc    = m_pc;
            m_ifid_pc1   = 16'(m_pc + 16'd1);
            m_ifid_instr = flush_i ? 16'h0000 : rom[m_pc[3:0]];
            m_ifid_valid = !flush_i;
            m_pc         = 16'(m_pc + 16'd1);
        end
    end

    always @(negedge clk) begin
        chk("model_imem_pc", imem_pc_o, m_pc);
        chk("model_valid", {15'd0, ifid_valid_o}, {15'd0, m_ifid_valid});
        chk("model_instr", ifid_instr_o, m_ifid_instr);
        chk("model_halted", {15'd0, halted_o}, {15'd0, m_halt});
        if (m_ifid_valid) begin
            chk("model_ifid_pc", ifid_pc_o, m_ifid_pc);
            chk("model_ifid_pc1", ifid_pc1_o, m_ifid_pc1);
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic expect_ifid(input string tag, input logic [15:0] pc, input logic [15:0] instr);
        chk({tag, "_valid"}, {15'd0, ifid_valid_o}, 16'd1);
        chk({tag, "_pc"}, ifid_pc_o, pc);
        chk({tag, "_pc1"}, ifid_pc1_o, 16'(pc + 16'd1));
        chk({tag, "_instr"}, ifid_instr_o, instr);
    endtask

    logic [15:0] last_valid_pc;
    logic        hit;

    initial begin
        for (int i = 0; i < 16; i++) rom[i] = 16'h1000 + 16'(i);
        rom[0] = 16'h444f; rom[1] = 16'h465f; rom[2] = 16'h14c0;
        rst = 1'b1; stall_i = 1'b0; flush_i = 1'b0; redirect_i = 1'b0; redirect_pc_i = 16'h0000;
        tick(); tick();
        chk("rst_imem_pc", imem_pc_o, 16'h0000);
        chk("rst_valid", {15'd0, ifid_valid_o}, 16'd0);
        chk("rst_instr", ifid_instr_o, 16'h0000);
        chk("rst_halted", {15'd0, halted_o}, 16'd0);

        // 1: boot bubble, then 444f/465f/14c0 on cycles 2/3/4 after reset release
        rst = 1'b0;
        tick();
        chk("boot_valid", {15'd0, ifid_valid_o}, 16'd0);
        chk("boot_imem_pc", imem_pc_o, 16'h0000);
        tick(); expect_ifid("c2", 16'd0, 16'h444f);
        tick(); expect_ifid("c3", 16'd1, 16'h465f);
        tick(); expect_ifid("c4", 16'd2, 16'h14c0);
        chk("c4_imem_pc", imem_pc_o, 16'd3);
`ifdef IF_PERF_CNT_EN
        chk("perf_fetch_3", perf_fetch_o, 16'd3);
        chk("perf_bubble_1", perf_bubble_o, 16'd1);
`endif

        // 6: asynchronous reset between edges takes effect at once
        rst = 1'b1;
        #1;
        chk("arst_imem_pc", imem_pc_o, 16'h0000);
        chk("arst_valid", {15'd0, ifid_valid_o}, 16'd0);
        chk("arst_instr", ifid_instr_o, 16'h0000);
        chk("arst_pc", ifid_pc_o, 16'h0000);
        chk("arst_pc1", ifid_pc1_o, 16'h0000);
`ifdef IF_PERF_CNT_EN
        chk("arst_perf_fetch", perf_fetch_o, 16'd0);
        chk("arst_perf_bubble", perf_bubble_o, 16'd0);
`endif
        tick();
        rst = 1'b0;
        tick(); tick(); tick();
        chk("pre_stall_imem_pc", imem_pc_o, 16'd2);

        // 2: two-cycle stall at pc=2
        stall_i = 1'b1;
        tick(); chk("stall1_imem_pc", imem_pc_o, 16'd2); expect_ifid("stall1", 16'd1, 16'h465f);
        tick(); chk("stall2_imem_pc", imem_pc_o, 16'd2); expect_ifid("stall2", 16'd1, 16'h465f);
        stall_i = 1'b0;
        tick(); expect_ifid("resume", 16'd2, 16'h14c0);
        tick(); chk("pre_flush_imem_pc", imem_pc_o, 16'd4);

        // 5: flush at pc=4 bubbles IF/ID but pc still advances
        flush_i = 1'b1;
        tick();
        flush_i = 1'b0;
        chk("flush_valid", {15'd0, ifid_valid_o}, 16'd0);
        chk("flush_instr", ifid_instr_o, 16'h0000);
        chk("flush_imem_pc", imem_pc_o, 16'd5);

        // 3: redirect wins over stall at pc=5
        stall_i = 1'b1; redirect_i = 1'b1; redirect_pc_i = 16'd0;
        tick();
        stall_i = 1'b0; redirect_i = 1'b0;
        chk("redir_imem_pc", imem_pc_o, 16'd0);
        chk("redir_valid", {15'd0, ifid_valid_o}, 16'd0);
        chk("redir_instr", ifid_instr_o, 16'h0000);
        tick(); expect_ifid("post_redir", 16'd0, 16'h444f);

        // 4: free run until the fetch walks off the end of the ROM
        hit = 1'b0; last_valid_pc = 16'hFFFF;
        for (int i = 0; i < 40 && !hit; i++) begin
            tick();
            if (halted_o) hit = 1'b1;
            else if (ifid_valid_o) last_valid_pc = ifid_pc_o;
        end
        chk("halt_reached", {15'd0, hit}, 16'd1);
        chk("last_fetch_pc", last_valid_pc, 16'd15);
        chk("halt_imem_pc", imem_pc_o, 16'd16);
        chk("halt_valid", {15'd0, ifid_valid_o}, 16'd0);
        tick();
        chk("halt_hold_pc", imem_pc_o, 16'd16);
        chk("halt_hold", {15'd0, halted_o}, 16'd1);
        redirect_i = 1'b1; redirect_pc_i = 16'd20;
        tick();
        chk("halt_oor_redirect", {15'd0, halted_o}, 16'd1);
        redirect_pc_i = 16'd3;
        tick();
        redirect_i = 1'b0;
        chk("unhalt", {15'd0, halted_o}, 16'd0);
        chk("unhalt_imem_pc", imem_pc_o, 16'd3);
        tick(); expect_ifid("unhalt_fetch", 16'd3, 16'h1003);
        tick(); tick();

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
